data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Word-organised data memory that acts as the responder end of the core's D-Memory request interface.
- Accepts one read or write request at a time, with per-byte write enables.
- Completes each request after a programmable latency and signals completion with a one-cycle Ack, which drives the memory controller's DataMem_Ack stall release.
- Sits between the core's D-Memory port and the board/testbench; also serves as the latency-configurable memory model for stall verification.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 2; ADDR_W = clog2(DEPTH).
- LATENCY, 2, cycles from request acceptance to Ack; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- Address  input  32  byte address; word index = Address[ADDR_W+1:2]; Address[1:0] ignored.
- WriteData  input  32  store data; byte lane i = bits 8i+7:8i.
- ReadEnable  input  1  read request.
- WriteEnable  input  1  write request.
- ByteEnable  input  4  write lane enables; bit i controls lane i.
- ReadData  output  32  read result; registered.
- Ack  output  1  one-cycle completion pulse.
- Busy  output  1  high while a request is in flight, Ack cycle included.
- Error  output  1  pulses with Ack when the request address is out of range.

Behaviour:
- Reset: synchronous, wins over all other activity. Forces state to IDLE, Ack=0, Busy=0, Error=0, ReadData=0, latency counter=0. Array contents are not cleared.
- States: IDLE, WAIT, ACK.
- IDLE:
  - If ReadEnable or WriteEnable is high at a rising edge, latch Address, WriteData, ByteEnable and op; set Busy=1.
  - Load counter = LATENCY-1.
  - Go to ACK if LATENCY=1, else WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter reaches 1, the next state is ACK.
  - Inputs are ignored in WAIT.
- ACK (exactly one cycle):
  - Ack=1 and Busy=1.
  - Error=1 if the latched upper address bits Address[31:ADDR_W+2] are nonzero.
  - Next state is IDLE; Ack, Busy and Error return to 0.
  - Requests present during ACK are ignored.
  - A request still high in the following IDLE cycle is accepted as a new transaction. The requester must drop its enables on the Ack cycle to avoid a repeat.
- Timing: request sampled at edge e; Ack is high during the cycle after edge e+LATENCY-1. Request-sample to Ack is LATENCY cycles; minimum turnaround between acceptances is LATENCY+1 cycles.
- Write:
  - Array update happens on the edge that enters ACK, applied only to lanes with ByteEnable[i]=1.
  - ByteEnable=0000 still completes with Ack and leaves the array unchanged.
  - An out-of-range write performs no array update.
- Read:
  - ReadData is loaded on the edge that enters ACK with the full word; ByteEnable is ignored.
  - An out-of-range read loads 0.
  - ReadData holds its value until the next read completes; writes do not alter it.
- Both enables high: treated as a write; ReadData unchanged.
- Reset during WAIT or ACK: transaction aborted, no array write, no Ack.
- Arithmetic: counter width 4 bits; no wrap, since it always reloads from LATENCY-1.

Test Plan:
- LATENCY=2, DEPTH=1024. Write 0xDEADBEEF to 0x10 with BE=1111, then read 0x10 → Ack high exactly 2 cycles after each request sample. ReadData=0xDEADBEEF in the read Ack cycle; Busy high for 2 cycles per request.
- Word at 0x20 = 0x11223344. Write 0x000000AA with BE=0001, then 0xBB000000 with BE=1000 → read returns 0xBB2233AA.
- Read at 0x1000 (index 1024, out of range) → Ack and Error high together, ReadData=0. Write to 0x1000 → Error=1 and array[0] unchanged.
- Assert RST in the WAIT cycle of a write of 0x55 to 0x8 → no Ack, Busy=0 next cycle, and a later read of 0x8 returns the prior contents.
- LATENCY=1, ReadEnable held high continuously → Ack pulses every 2 cycles, and Busy drops for exactly one cycle between transactions.
- ReadEnable and WriteEnable both high with WriteData=0x0F0F0F0F at 0x4 → treated as a write: ReadData unchanged, and a subsequent read returns 0x0F0F0F0F.

Source files
------------

// File: rtl/data_memory_responder.sv
// Word-organised data memory answering D-Memory requests after a fixed latency,
// with per-byte write lanes and an out-of-range error flag on the Ack pulse.
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        ReadEnable,
    input  logic        WriteEnable,
    input  logic [3:0]  ByteEnable,
    output logic [31:0] ReadData,
    output logic        Ack,
    output logic        Busy,
    output logic        Error
);

    localparam int         ADDR_W   = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam bit         LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [29:0]  r_waddr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_be;
    logic         r_is_wr;
    logic [31:0]  r_mem [DEPTH];

    logic              w_req;
    logic              w_fire;
    logic [29:0]       w_op_waddr;
    logic [31:0]       w_op_wdata;
    logic [3:0]        w_op_be;
    logic              w_op_wr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic              w_mem_we;
    logic              w_unused;

    // Byte offset bits carry no meaning for a word-organised array.
    assign w_unused = ^Address[1:0];
    assign w_req    = ReadEnable | WriteEnable;

    // Operand source: live inputs while idle (the LATENCY=1 fast path), latched copy otherwise.
    always_comb begin
        w_op_waddr = r_waddr;
        w_op_wdata = r_wdata;
        w_op_be    = r_be;
        w_op_wr    = r_is_wr;
        if (r_state == S_IDLE) begin
            w_op_waddr = Address[31:2];
            w_op_wdata = WriteData;
            w_op_be    = ByteEnable;
            w_op_wr    = WriteEnable;
        end else begin
            w_op_waddr = r_waddr;
            w_op_wdata = r_wdata;
            w_op_be    = r_be;
            w_op_wr    = r_is_wr;
        end
    end

    // Completion strobe: asserted on the edge that moves the FSM into ACK.
    always_comb begin
        w_fire = 1'b0;
        case (r_state)
            S_IDLE:  w_fire = w_req & LAT_ONE;
            S_WAIT:  w_fire = (r_cnt == 4'd1);
            default: w_fire = 1'b0;
        endcase
    end

    assign w_idx    = w_op_waddr[ADDR_W-1:0];
    assign w_oor    = |(w_op_waddr >> ADDR_W);
    assign w_mem_we = w_fire & w_op_wr & ~w_oor & ~RST;

    // Storage array: lane-masked write, never reset so contents survive RST.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered Ack/Busy/Error/ReadData.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_waddr  <= 30'd0;
            r_wdata  <= 32'd0;
            r_be     <= 4'd0;
            r_is_wr  <= 1'b0;
            Ack      <= 1'b0;
            Busy     <= 1'b0;
            Error    <= 1'b0;
            ReadData <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_waddr <= Address[31:2];
                        r_wdata <= WriteData;
                        r_be    <= ByteEnable;
                        r_is_wr <= WriteEnable;
                        r_cnt   <= CNT_INIT;
                        Busy    <= 1'b1;
                        r_state <= LAT_ONE ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    Ack     <= 1'b0;
                    Busy    <= 1'b0;
                    Error   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    Ack     <= 1'b0;
                    Busy    <= 1'b0;
                    Error   <= 1'b0;
                end
            endcase
            // Reads take the whole word; out-of-range reads return zero.
            if (w_fire) begin
                Ack   <= 1'b1;
                Error <= w_oor;
                if (!w_op_wr) begin
                    ReadData <= w_oor ? 32'd0 : r_mem[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: a LATENCY=2 instance driven by directed and random requests,
// plus a LATENCY=1 instance exercising back-to-back held reads.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] Address, WriteData, ReadData;
    logic        ReadEnable, WriteEnable, Ack, Busy, Error;
    logic [3:0]  ByteEnable;

    logic [31:0] a1, wd1, rd1;
    logic        re1, we1, ack1, busy1, err1;
    logic [3:0]  be1;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .CLK(clk), .RST(RST), .Address(Address), .WriteData(WriteData),
        .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .ByteEnable(ByteEnable),
        .ReadData(ReadData), .Ack(Ack), .Busy(Busy), .Error(Error)
    );

    data_memory_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .CLK(clk), .RST(RST), .Address(a1), .WriteData(wd1),
        .ReadEnable(re1), .WriteEnable(we1), .ByteEnable(be1),
        .ReadData(rd1), .Ack(ack1), .Busy(busy1), .Error(err1)
    );

    typedef struct {
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] mem_m [1024];
    logic [31:0] last_rd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected outcome derived from address range and lane rules.
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        int   n;
        @(negedge clk);
        Address = a; WriteData = d; ByteEnable = be;
        ReadEnable = rd; WriteEnable = wr;
        e.err = (a[31:12] != 20'd0);
        e.cyc = cyc + 2;
        if (wr) begin
            if (!e.err) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_m[a[11:2]][8*i +: 8] = d[8*i +: 8];
            end
            e.data = last_rd;
        end else begin
            e.data  = e.err ? 32'd0 : mem_m[a[11:2]];
            last_rd = e.data;
        end
        sb.push_back(e);
        @(negedge clk);
        ReadEnable = 1'b0; WriteEnable = 1'b0;
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 32'd2);
    endtask

    // Monitor: every Ack is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (Ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("error", {31'd0, Error}, {31'd0, e.err});
                chk("readdata", ReadData, e.data);
                chk("busy_at_ack", {31'd0, Busy}, 32'd1);
            end
        end else begin
            chk("error_without_ack", {31'd0, Error}, 32'd0);
        end
    end

    initial begin
        int          w, r;
        logic [31:0] a;
        RST = 1'b1; Address = 32'd0; WriteData = 32'd0; ByteEnable = 4'd0;
        ReadEnable = 1'b0; WriteEnable = 1'b0;
        a1 = 32'd0; wd1 = 32'd0; re1 = 1'b0; we1 = 1'b0; be1 = 4'd0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'd0, Ack}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);

        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

        req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        req(1'b0, 1'b1, 32'h20, 32'h000000AA, 4'b0001);
        req(1'b0, 1'b1, 32'h20, 32'hBB000000, 4'b1000);
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        req(1'b0, 1'b1, 32'h20, 32'h99999999, 4'b0000);
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);

        req(1'b0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF);
        req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
        req(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset lands in the WAIT cycle of a write: no Ack, no array update.
        req(1'b0, 1'b1, 32'h8, 32'h12345678, 4'hF);
        @(negedge clk);
        Address = 32'h8; WriteData = 32'h55; ByteEnable = 4'hF; WriteEnable = 1'b1;
        @(negedge clk);
        WriteEnable = 1'b0; RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        last_rd = 32'd0;
        chk("abort_ack", {31'd0, Ack}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_readdata", ReadData, 32'd0);
        req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);

        req(1'b1, 1'b1, 32'h4, 32'h0F0F0F0F, 4'hF);
        req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);

        // Random traffic over 16 fully-initialised words plus out-of-range hits.
        for (int i = 0; i < 16; i++) req(1'b0, 1'b1, i * 4, $urandom, 4'hF);
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 15);
            a = w * 4 + $urandom_range(0, 3);
            if (r == 0) a = $urandom | 32'h1000;
            if (r < 4)      req(1'b1, 1'b0, a, $urandom, 4'($urandom));
            else if (r < 8) req(1'b0, 1'b1, a, $urandom, 4'($urandom));
            else            req(1'b1, 1'b1, a, $urandom, 4'($urandom));
        end

        // LATENCY=1 instance: write, then hold ReadEnable high continuously.
        @(negedge clk);
        a1 = 32'h0; wd1 = 32'hCAFEF00D; be1 = 4'hF; we1 = 1'b1;
        @(negedge clk);
        chk("l1_write_ack", {31'd0, ack1}, 32'd1);
        we1 = 1'b0; re1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("l1_gap_ack", {31'd0, ack1}, 32'd0);
            chk("l1_gap_busy", {31'd0, busy1}, 32'd0);
            @(negedge clk);
            chk("l1_ack", {31'd0, ack1}, 32'd1);
            chk("l1_busy", {31'd0, busy1}, 32'd1);
            chk("l1_readdata", rd1, 32'hCAFEF00D);
            chk("l1_error", {31'd0, err1}, 32'd0);
        end
        re1 = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
